// File: rtl/fractal_pkg.sv
// Shared types and constants for the fractal coefficient packer.
// Holds the FIFO entry layout, the packer state enum and word-extraction helpers.
package fractal_pkg;

  localparam int COEFF_W  = 128;
  localparam int STREAM_W = 32;
  localparam logic [7:0] HDR_MAGIC = 8'hFC;

  typedef enum logic [1:0] {IDLE, HDR, DATA} pack_state_e;

  typedef struct packed {
    logic               q;
    logic [15:0]        seq;
    logic [COEFF_W-1:0] coeff;
  } fifo_entry_t;

  function automatic logic [STREAM_W-1:0] hdr_word(input logic q, input logic [15:0] seq);
    return {HDR_MAGIC, 7'b0, q, seq};
  endfunction

  // idx 0 selects the most significant word
  function automatic logic [STREAM_W-1:0] coeff_word(input logic [COEFF_W-1:0] c,
                                                    input logic [1:0] idx);
    return c[{~idx, 5'b00000} +: STREAM_W];
  endfunction

endpackage

// File: rtl/coeff_fifo.sv
// Synchronous FIFO with push/pop/full/empty/level; read data is combinational from the head.
// A push while full is accepted only when a pop happens in the same cycle.
module coeff_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign level   = cnt_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/fractal_coeff_packer.sv
// Buffers kernel coefficients and serialises each into header + 4 data words (MSW first).
// Header appears 2 cycles after coeff_valid when idle; stalls hold outputs, FIFO-full arrivals are dropped.
module fractal_coeff_packer
  import fractal_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [127:0]             coeff_in,
  input  logic                     coeff_valid,
  input  logic                     quantum_flag,
  output logic [31:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [15:0]              drop_count
);

  pack_state_e        state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [COEFF_W-1:0] hold_q, hold_d;
  logic [31:0]        m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [15:0]        seq_q, seq_d, drop_count_q, drop_count_d;
  logic               overflow_q, overflow_d;

  fifo_entry_t push_ent, pop_ent;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty, drop, load, xfer;

  assign push_ent = '{q: quantum_flag, seq: seq_q, coeff: coeff_in};
  assign xfer     = m_valid_q & m_ready;

  coeff_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .push_dat(push_ent),
    .pop     (fifo_pop),
    .pop_dat (pop_ent),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    load      = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: load = ~fifo_empty;
      HDR: if (xfer) begin
        state_d  = DATA;
        idx_d    = 2'd0;
        m_data_d = coeff_word(hold_q, 2'd0);
      end
      DATA: if (xfer) begin
        if (idx_q == 2'd3) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_data_d  = '0;
          end
        end else begin
          idx_d    = idx_q + 2'd1;
          m_data_d = coeff_word(hold_q, idx_d);
          m_last_d = (idx_d == 2'd3);
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading the next coefficient straight into HDR avoids a bubble between coefficients
    if (load) begin
      fifo_pop  = 1'b1;
      hold_d    = pop_ent.coeff;
      state_d   = HDR;
      m_valid_d = 1'b1;
      m_last_d  = 1'b0;
      m_data_d  = hdr_word(pop_ent.q, pop_ent.seq);
    end
  end

  always_comb begin
    fifo_push    = coeff_valid & (~fifo_full | fifo_pop);
    drop         = coeff_valid & fifo_full & ~fifo_pop;
    seq_d        = fifo_push ? seq_q + 16'd1 : seq_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d   = 1'b1;
      drop_count_d = ovf_clr ? 16'd1 :
                     (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;
    end else if (ovf_clr) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      seq_q        <= seq_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
